// File: rtl/netguard_pkg.sv
// -----------------------------------------------------------------------------
// netguard_pkg
//   Types and constants shared by the NetGuard access path: access_arbiter,
//   its bus interface and the downstream access_system lookup.
//   - NG_ID_W     : user/resource ID width common to arbiter and access_system
//   - acc_state_t : arbiter FSM state encoding
//   - LOG_*       : two-bit log record flag codes written to the activity log
// -----------------------------------------------------------------------------
package netguard_pkg;

    localparam int NG_ID_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_LOG    = 3'd3,
        ST_REJECT = 3'd4
    } acc_state_t;

    localparam logic [1:0] LOG_OK     = 2'b00;
    localparam logic [1:0] LOG_BADID  = 2'b01;
    localparam logic [1:0] LOG_REPEAT = 2'b10;

endpackage

// File: rtl/access_arbiter_if.sv
// -----------------------------------------------------------------------------
// access_arbiter_if
//   Bundles the requester handshake, the access_system lookup port and the
//   log sink of access_arbiter.
//   Signals:
//     req, req_user            requester side (req_user slice i = [i*ID_W +: ID_W])
//     grant, reject            one-hot per-requester result pulses
//     user_id, user_valid      lookup request to access_system
//     resource_id              lookup answer from access_system
//     log_valid/ts/user/       timestamped log record
//     log_resource/log_flag
//     alarm, alarm_clr         sticky alarm and its clear
//   Modports:
//     slave  : the arbiter
//     master : everything around it (requesters, access_system, log sink)
// -----------------------------------------------------------------------------
interface access_arbiter_if
    import netguard_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = NG_ID_W,
    parameter int TS_W    = 16
);
    logic [NUM_REQ-1:0]      req;
    logic [NUM_REQ*ID_W-1:0] req_user;
    logic [NUM_REQ-1:0]      grant;
    logic [NUM_REQ-1:0]      reject;
    logic [ID_W-1:0]         user_id;
    logic                    user_valid;
    logic [ID_W-1:0]         resource_id;
    logic                    log_valid;
    logic [TS_W-1:0]         log_ts;
    logic [ID_W-1:0]         log_user;
    logic [ID_W-1:0]         log_resource;
    logic [1:0]              log_flag;
    logic                    alarm;
    logic                    alarm_clr;

    modport slave (
        input  req, req_user, resource_id, alarm_clr,
        output grant, reject, user_id, user_valid,
               log_valid, log_ts, log_user, log_resource, log_flag, alarm
    );

    modport master (
        output req, req_user, resource_id, alarm_clr,
        input  grant, reject, user_id, user_valid,
               log_valid, log_ts, log_user, log_resource, log_flag, alarm
    );

endinterface

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Round-robin winner select. The winner is the first requesting index at or
//   after the pointer, wrapping. When i_advance is high the pointer moves to
//   the slot just after the current winner.
//   Ports:
//     clk, rst    clock, synchronous active-high reset (pointer -> 0)
//     i_req       request vector
//     i_advance   accept the current winner and move the pointer
//     o_any       at least one request present
//     o_win       index of the winner (valid when o_any)
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_advance,
    output logic               o_any,
    output logic [IDX_W-1:0]   o_win
);
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_idx;

    // Scan from the pointer outward; the first hit is kept.
    always_comb begin
        o_any = 1'b0;
        o_win = '0;
        w_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = IDX_W'((int'(r_ptr) + k) % NUM_REQ);
            if (!o_any && i_req[w_idx]) begin
                o_any = 1'b1;
                o_win = w_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            r_ptr <= (o_win == IDX_W'(NUM_REQ - 1)) ? '0 : o_win + 1'b1;
        end
    end

endmodule

// File: rtl/access_arbiter.sv
// -----------------------------------------------------------------------------
// access_arbiter
//   Shares one access_system lookup port among NUM_REQ requesters with
//   round-robin arbitration, rejects out-of-range user IDs, flags bursts of
//   REPEAT_LIMIT or more consecutive grants to the same user, and emits a
//   timestamped log record for every transaction.
//   Ports:
//     clk   single clock, rising edge
//     rst   synchronous active-high reset; aborts any transaction in flight
//     bus   access_arbiter_if.slave: requester handshake, lookup port,
//           log record outputs and sticky alarm
// -----------------------------------------------------------------------------
module access_arbiter
    import netguard_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int ID_W         = NG_ID_W,
    parameter int MAX_VALID_ID = 9,
    parameter int REPEAT_LIMIT = 8,
    parameter int ACC_LAT      = 1,
    parameter int TS_W         = 16
) (
    input  logic            clk,
    input  logic            rst,
    access_arbiter_if.slave bus
);
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W  = $clog2(REPEAT_LIMIT + 1);
    localparam int WAIT_W = (ACC_LAT > 1) ? $clog2(ACC_LAT) : 1;

    acc_state_t          r_state;
    logic [NUM_REQ-1:0]  r_grant;
    logic [NUM_REQ-1:0]  r_reject;
    logic                r_user_valid;
    logic [ID_W-1:0]     r_user_id;
    logic [ID_W-1:0]     r_id;
    logic [ID_W-1:0]     r_last_id;
    logic [CNT_W-1:0]    r_rep_cnt;
    logic [WAIT_W-1:0]   r_wait;
    logic                r_log_valid;
    logic [TS_W-1:0]     r_log_ts;
    logic [ID_W-1:0]     r_log_user;
    logic [ID_W-1:0]     r_log_resource;
    logic [1:0]          r_log_flag;
    logic [TS_W-1:0]     r_ts;
    logic                r_alarm;

    logic                w_any;
    logic [IDX_W-1:0]    w_win;
    logic [ID_W-1:0]     w_id;
    logic [NUM_REQ-1:0]  w_onehot;
    logic                w_bad;
    logic                w_advance;
    logic [TS_W-1:0]     w_ts_next;

    // Saturating increment of the repeat counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= CNT_W'(REPEAT_LIMIT)) ? CNT_W'(REPEAT_LIMIT) : v + 1'b1;
    endfunction

    // Flag carried by a successful record for a given repeat count.
    function automatic logic [1:0] grant_flag(input logic [CNT_W-1:0] cnt);
        return (cnt == CNT_W'(REPEAT_LIMIT)) ? LOG_REPEAT : LOG_OK;
    endfunction

    // Arbitration only advances when the FSM actually accepts a winner.
    assign w_advance = (r_state == ST_IDLE) && w_any;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .clk       (clk),
        .rst       (rst),
        .i_req     (bus.req),
        .i_advance (w_advance),
        .o_any     (w_any),
        .o_win     (w_win)
    );

    always_comb begin
        w_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == IDX_W'(i)) begin
                w_id = bus.req_user[i*ID_W +: ID_W];
            end
        end
    end

    assign w_onehot  = NUM_REQ'(1) << w_win;
    assign w_bad     = int'(w_id) > MAX_VALID_ID;
    // Outputs are registered, so a record stamped now appears next cycle
    // and must carry next cycle's timestamp.
    assign w_ts_next = r_ts + 1'b1;

    // ---- timestamp: free-running, wraps naturally at TS_W bits ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ts <= '0;
        end else begin
            r_ts <= w_ts_next;
        end
    end

    // ---- transaction FSM with registered outputs and repeat tracker ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_grant        <= '0;
            r_reject       <= '0;
            r_user_valid   <= 1'b0;
            r_user_id      <= '0;
            r_log_valid    <= 1'b0;
            r_log_ts       <= '0;
            r_log_user     <= '0;
            r_log_resource <= '0;
            r_log_flag     <= LOG_OK;
            r_last_id      <= '0;
            r_rep_cnt      <= '0;
            r_wait         <= '0;
        end else begin
            r_grant      <= '0;
            r_reject     <= '0;
            r_user_valid <= 1'b0;
            r_log_valid  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_id <= w_id;
                        if (w_bad) begin
                            r_state        <= ST_REJECT;
                            r_reject       <= w_onehot;
                            r_log_valid    <= 1'b1;
                            r_log_ts       <= w_ts_next;
                            r_log_user     <= w_id;
                            r_log_resource <= '0;
                            r_log_flag     <= LOG_BADID;
                        end else begin
                            r_state      <= ST_ISSUE;
                            r_grant      <= w_onehot;
                            r_user_valid <= 1'b1;
                            r_user_id    <= w_id;
                        end
                    end
                end
                ST_ISSUE: begin
                    // Tracker updates here so the LOG flag sees the new count.
                    if (r_id == r_last_id) begin
                        r_rep_cnt <= sat_inc(r_rep_cnt);
                    end else begin
                        r_rep_cnt <= CNT_W'(1);
                        r_last_id <= r_id;
                    end
                    r_wait  <= WAIT_W'(ACC_LAT - 1);
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_wait == '0) begin
                        r_state        <= ST_LOG;
                        r_log_valid    <= 1'b1;
                        r_log_ts       <= w_ts_next;
                        r_log_user     <= r_id;
                        r_log_resource <= bus.resource_id;
                        r_log_flag     <= grant_flag(r_rep_cnt);
                    end else begin
                        r_wait <= r_wait - 1'b1;
                    end
                end
                ST_LOG, ST_REJECT: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ---- sticky alarm: a flagged record beats a simultaneous clear ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alarm <= 1'b0;
        end else if (r_log_valid && (r_log_flag != LOG_OK)) begin
            r_alarm <= 1'b1;
        end else if (bus.alarm_clr) begin
            r_alarm <= 1'b0;
        end
    end

    assign bus.grant        = r_grant;
    assign bus.reject       = r_reject;
    assign bus.user_id      = r_user_id;
    assign bus.user_valid   = r_user_valid;
    assign bus.log_valid    = r_log_valid;
    assign bus.log_ts       = r_log_ts;
    assign bus.log_user     = r_log_user;
    assign bus.log_resource = r_log_resource;
    assign bus.log_flag     = r_log_flag;
    assign bus.alarm        = r_alarm;

endmodule

// File: tb/tb_access_arbiter.sv
// -----------------------------------------------------------------------------
// tb_access_arbiter
//   Bench for access_arbiter. A main instance (NUM_REQ=4, TS_W=16) runs
//   hand-written sequences and a vector table; a second instance (NUM_REQ=2,
//   TS_W=4) runs free with two requesters to exercise timestamp wrap.
//   Expected log records are queued when stimulus is driven and compared by a
//   monitor when log_valid appears.
// -----------------------------------------------------------------------------
module tb_access_arbiter;
    import netguard_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    access_arbiter_if #(.NUM_REQ(4), .ID_W(4), .TS_W(16)) bus  ();
    access_arbiter_if #(.NUM_REQ(2), .ID_W(4), .TS_W(4))  bus2 ();

    access_arbiter #(
        .NUM_REQ(4), .ID_W(4), .MAX_VALID_ID(9), .REPEAT_LIMIT(8),
        .ACC_LAT(1), .TS_W(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    access_arbiter #(
        .NUM_REQ(2), .ID_W(4), .MAX_VALID_ID(9), .REPEAT_LIMIT(8),
        .ACC_LAT(1), .TS_W(4)
    ) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    // Stand-in for access_system: resource is a fixed map of the user ID.
    function automatic logic [3:0] rmap(input logic [3:0] u);
        return u * 4'd3 + 4'd1;
    endfunction

    assign bus.resource_id  = rmap(bus.user_id);
    assign bus2.resource_id = rmap(bus2.user_id);

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: required event did not occur as expected", name);
    endtask

    // Reference cycle count since reset release.
    logic [15:0] mts;
    always @(posedge clk) begin
        if (rst) mts <= '0;
        else     mts <= mts + 16'd1;
    end

    typedef struct {
        logic [3:0] user;
        logic [3:0] res;
        logic [1:0] flag;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [15:0] log_cyc_q[$];
    logic [15:0] last_log_ts;
    int          n_logs = 0;
    bit          excl_ok;

    // ---- main-instance monitor ----
    always @(negedge clk) begin
        if ((|bus.grant) || (|bus.reject) || bus.log_valid) begin
            excl_ok = !((|bus.grant) && (bus.log_valid || (|bus.reject))) &&
                      $onehot0(bus.grant | bus.reject);
            chk("exclusive_outputs", 32'(excl_ok), 32'd1);
        end
        if (bus.log_valid) begin
            n_logs++;
            log_cyc_q.push_back(mts);
            last_log_ts = bus.log_ts;
            chk("log_ts", 32'(bus.log_ts), 32'(mts));
            if (sb.size() == 0) begin
                fail_evt("unexpected_log_record");
            end else begin
                mon_e = sb.pop_front();
                chk("log_user",     32'(bus.log_user),     32'(mon_e.user));
                chk("log_resource", 32'(bus.log_resource), 32'(mon_e.res));
                chk("log_flag",     32'(bus.log_flag),     32'(mon_e.flag));
            end
        end
    end

    // ---- second-instance monitor (TS_W = 4) ----
    int n2    = 0;
    bit wrap2 = 1'b0;
    always @(negedge clk) begin
        if (bus2.log_valid) begin
            n2++;
            chk("ts4_log_ts",   32'(bus2.log_ts),   32'(mts[3:0]));
            chk("ts4_log_flag", 32'(bus2.log_flag), 32'(LOG_OK));
            chk("ts4_log_res",  32'(bus2.log_resource), 32'(rmap(bus2.log_user)));
            if (mts > 16'd15) wrap2 = 1'b1;
        end
    end

    task automatic wait_drain();
        int c = 0;
        while (sb.size() != 0 && c < 30) begin
            @(posedge clk); #2;
            c++;
        end
        if (sb.size() != 0) begin
            fail_evt("record_drain_timeout");
            sb.delete();
        end
    endtask

    task automatic do_txn(input int idx, input logic [3:0] id,
                          input logic [1:0] flag, input bit bad);
        exp_t e;
        bit   seen;
        e.user = id;
        e.res  = bad ? 4'd0 : rmap(id);
        e.flag = flag;
        @(posedge clk); #1;
        sb.push_back(e);
        bus.req[idx] = 1'b1;
        bus.req_user[idx*4 +: 4] = id;
        seen = 1'b0;
        for (int c = 0; c < 12 && !seen; c++) begin
            @(negedge clk);
            if (bus.grant[idx] || bus.reject[idx]) begin
                seen = 1'b1;
                chk("txn_is_reject", 32'(bus.reject[idx]), 32'(bad));
                if (!bad) begin
                    chk("txn_user_id",    32'(bus.user_id),    32'(id));
                    chk("txn_user_valid", 32'(bus.user_valid), 32'd1);
                end
            end
        end
        if (!seen) fail_evt("txn_response_timeout");
        @(posedge clk); #1;
        bus.req[idx] = 1'b0;
        wait_drain();
    endtask

    typedef struct {
        int         idx;
        logic [3:0] user;
        logic [1:0] flag;
        bit         bad;
    } vec_t;

    localparam int NV = 16;
    vec_t tbl[NV];

    int          n_before;
    bit          seen_g;
    logic [3:0]  rr_exp[5];
    exp_t        e0;

    initial begin
        // Repeat burst of ID 4 with a reject in the middle, then range edges.
        tbl[0]  = '{1, 4'd4,  LOG_OK,     1'b0};
        tbl[1]  = '{2, 4'd4,  LOG_OK,     1'b0};
        tbl[2]  = '{3, 4'd4,  LOG_OK,     1'b0};
        tbl[3]  = '{0, 4'd4,  LOG_OK,     1'b0};
        tbl[4]  = '{1, 4'd4,  LOG_OK,     1'b0};
        tbl[5]  = '{2, 4'd13, LOG_BADID,  1'b1};
        tbl[6]  = '{3, 4'd4,  LOG_OK,     1'b0};
        tbl[7]  = '{0, 4'd4,  LOG_OK,     1'b0};
        tbl[8]  = '{1, 4'd4,  LOG_REPEAT, 1'b0};
        tbl[9]  = '{2, 4'd4,  LOG_REPEAT, 1'b0};
        tbl[10] = '{3, 4'd4,  LOG_REPEAT, 1'b0};
        tbl[11] = '{0, 4'd5,  LOG_OK,     1'b0};
        tbl[12] = '{1, 4'd5,  LOG_OK,     1'b0};
        tbl[13] = '{2, 4'd9,  LOG_OK,     1'b0};
        tbl[14] = '{3, 4'd10, LOG_BADID,  1'b1};
        tbl[15] = '{0, 4'd0,  LOG_OK,     1'b0};

        bus.req       = '0;
        bus.req_user  = '0;
        bus.alarm_clr = 1'b0;
        bus2.req      = 2'b11;
        bus2.req_user = {4'd8, 4'd7};
        bus2.alarm_clr = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_grant",      32'(bus.grant),      32'd0);
        chk("rst_reject",     32'(bus.reject),     32'd0);
        chk("rst_user_valid", 32'(bus.user_valid), 32'd0);
        chk("rst_user_id",    32'(bus.user_id),    32'd0);
        chk("rst_log_valid",  32'(bus.log_valid),  32'd0);
        chk("rst_log_ts",     32'(bus.log_ts),     32'd0);
        chk("rst_alarm",      32'(bus.alarm),      32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single requester, ID 3, req in cycle 2
        while (mts != 16'd2) begin
            @(posedge clk); #1;
        end
        e0.user = 4'd3; e0.res = rmap(4'd3); e0.flag = LOG_OK;
        sb.push_back(e0);
        bus.req[0] = 1'b1;
        bus.req_user[3:0] = 4'd3;
        @(negedge clk);
        chk("t1_no_grant_yet", 32'(bus.grant), 32'd0);
        @(negedge clk);
        chk("t1_grant",       32'(bus.grant),      32'b0001);
        chk("t1_grant_cycle", 32'(mts),            32'd3);
        chk("t1_user_id",     32'(bus.user_id),    32'd3);
        chk("t1_user_valid",  32'(bus.user_valid), 32'd1);
        @(posedge clk); #1;
        bus.req[0] = 1'b0;
        wait_drain();
        chk("t1_log_ts", 32'(last_log_ts), 32'd5);

        // Reject of ID 12 on requester 2, latency one cycle
        @(posedge clk); #1;
        e0.user = 4'd12; e0.res = 4'd0; e0.flag = LOG_BADID;
        sb.push_back(e0);
        bus.req[2] = 1'b1;
        bus.req_user[11:8] = 4'd12;
        @(negedge clk);
        chk("rej_not_yet", 32'(bus.reject), 32'd0);
        @(negedge clk);
        chk("rej_pulse",     32'(bus.reject),    32'b0100);
        chk("rej_log_valid", 32'(bus.log_valid), 32'd1);
        @(posedge clk); #1;
        bus.req[2] = 1'b0;
        wait_drain();
        @(negedge clk);
        chk("alarm_set", 32'(bus.alarm), 32'd1);
        @(posedge clk); #1;
        bus.alarm_clr = 1'b1;
        @(posedge clk); #1;
        bus.alarm_clr = 1'b0;
        @(negedge clk);
        chk("alarm_cleared", 32'(bus.alarm), 32'd0);

        // Clear coinciding with a BADID record: set wins
        @(posedge clk); #1;
        e0.user = 4'd15; e0.res = 4'd0; e0.flag = LOG_BADID;
        sb.push_back(e0);
        bus.req[1] = 1'b1;
        bus.req_user[7:4] = 4'd15;
        @(posedge clk); #1;
        bus.alarm_clr = 1'b1;
        @(negedge clk);
        chk("rej2_pulse", 32'(bus.reject), 32'b0010);
        @(posedge clk); #1;
        bus.alarm_clr = 1'b0;
        bus.req[1] = 1'b0;
        @(negedge clk);
        chk("alarm_set_beats_clr", 32'(bus.alarm), 32'd1);
        wait_drain();

        // Reset during WAIT aborts the transaction
        @(posedge clk); #1;
        bus.req[2] = 1'b1;
        bus.req_user[11:8] = 4'd6;
        seen_g = 1'b0;
        for (int c = 0; c < 10 && !seen_g; c++) begin
            @(negedge clk);
            if (bus.grant[2]) seen_g = 1'b1;
        end
        if (!seen_g) fail_evt("rstwait_grant_timeout");
        @(posedge clk); #1;
        bus.req[2] = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstwait_alarm",     32'(bus.alarm),     32'd0);
        chk("rstwait_log_valid", 32'(bus.log_valid), 32'd0);
        chk("rstwait_user_id",   32'(bus.user_id),   32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        n_before = n_logs;
        repeat (6) @(posedge clk);
        chk("rstwait_no_record", 32'(n_logs), 32'(n_before));

        // All four requesting: order 0,1,2,3,0 from a reset pointer
        rr_exp[0] = 4'd1; rr_exp[1] = 4'd2; rr_exp[2] = 4'd3;
        rr_exp[3] = 4'd5; rr_exp[4] = 4'd1;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            e0.user = rr_exp[k]; e0.res = rmap(rr_exp[k]); e0.flag = LOG_OK;
            sb.push_back(e0);
        end
        log_cyc_q.delete();
        bus.req_user = {4'd5, 4'd3, 4'd2, 4'd1};
        bus.req      = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            seen_g = 1'b0;
            for (int c = 0; c < 10 && !seen_g; c++) begin
                @(negedge clk);
                if (|bus.grant) seen_g = 1'b1;
            end
            if (!seen_g) fail_evt("rr_grant_timeout");
            chk("rr_grant_order", 32'(bus.grant), 32'(4'b0001 << (k % 4)));
        end
        @(posedge clk); #1;
        bus.req = '0;
        wait_drain();
        if (log_cyc_q.size() == 5) begin
            for (int k = 1; k < 5; k++) begin
                chk("rr_record_spacing", 32'(log_cyc_q[k] - log_cyc_q[k-1]), 32'd4);
            end
        end else begin
            fail_evt("rr_record_count");
        end

        // Vector table: repeat tracker and ID range edges
        for (int i = 0; i < NV; i++) begin
            do_txn(tbl[i].idx, tbl[i].user, tbl[i].flag, tbl[i].bad);
        end

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("sb_empty",       32'(sb.size()), 32'd0);
        chk("ts4_wrap_seen",  32'(wrap2),     32'd1);
        chk("ts4_records_10", 32'(n2 >= 10),  32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required $finish before 100000");
        $fatal(1);
    end

endmodule
